// File: rtl/nibble_stream_sequencer.sv
// Byte-to-nibble serialiser on valid/ready streams with framing and a completed-byte counter.
// Optional even-parity output on each nibble when NIBBLE_PARITY_EN is defined.
module nibble_stream_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_swap,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_nibble,
    output logic             out_first,
    output logic             out_last,
    output logic             busy,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] byte_cnt
`ifdef NIBBLE_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NIB0 = 2'd1;
    localparam logic [1:0] NIB1 = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [7:0] byte_q;
    logic       last_q;
    logic       swap_q;
    logic       accept;
    logic       nib1_done;

    // State register and byte/config capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
            swap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                byte_q <= in_data;
                last_q <= in_last;
                swap_q <= cfg_swap;
            end
        end
    end

    // Clear takes priority over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt <= '0;
        end else if (clr_cnt) begin
            byte_cnt <= '0;
        end else if (nib1_done) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

    // Next-state and stream outputs
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_nibble = 4'h0;
        out_first  = 1'b0;
        out_last   = 1'b0;
        nib1_done  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_d = NIB0;
            end
            NIB0: begin
                out_valid  = 1'b1;
                out_first  = 1'b1;
                out_nibble = swap_q ? byte_q[7:4] : byte_q[3:0];
                if (out_ready) state_d = NIB1;
            end
            NIB1: begin
                out_valid  = 1'b1;
                out_last   = last_q;
                out_nibble = swap_q ? byte_q[3:0] : byte_q[7:4];
                in_ready   = rst_n & out_ready;
                nib1_done  = out_ready;
                if (out_ready) state_d = in_valid ? NIB0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign busy   = (state_q != IDLE);

`ifdef NIBBLE_PARITY_EN
    assign out_parity = ^out_nibble;
`endif

endmodule

// File: tb/tb_nibble_stream_sequencer.sv
// Directed self-checking bench for nibble_stream_sequencer (counter built 4 bits wide for wrap).
module tb_nibble_stream_sequencer;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_swap;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_nibble;
    logic             out_first;
    logic             out_last;
    logic             busy;
    logic             clr_cnt;
    logic [CNT_W-1:0] byte_cnt;
`ifdef NIBBLE_PARITY_EN
    logic             out_parity;
`endif

    int total = 0;
    int bad   = 0;

    nibble_stream_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_swap(cfg_swap), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_nibble(out_nibble),
        .out_first(out_first), .out_last(out_last), .busy(busy),
        .clr_cnt(clr_cnt), .byte_cnt(byte_cnt)
`ifdef NIBBLE_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then let inputs settle before sampling
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic s, input logic clr1);
        in_valid = 1'b1; in_data = d; in_last = l; cfg_swap = s; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        clr_cnt = clr1;
        cyc();
        clr_cnt = 1'b0;
    endtask

    logic [7:0] stream [3];
    logic [3:0] exp_nib [6];

    initial begin
        stream[0] = 8'h12; stream[1] = 8'h34; stream[2] = 8'h56;
        exp_nib[0] = 4'h2; exp_nib[1] = 4'h1; exp_nib[2] = 4'h4;
        exp_nib[3] = 4'h3; exp_nib[4] = 4'h6; exp_nib[5] = 4'h5;

        rst_n = 1'b0; cfg_swap = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_last = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        cyc(); cyc();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", byte_cnt, 0);
        check("rst_nibble", out_nibble, 0);
        rst_n = 1'b1; settle();
        check("idle_in_ready", in_ready, 1);

        // 1: lower nibble first
        in_valid = 1'b1; in_data = 8'hA5; cfg_swap = 1'b0; out_ready = 1'b1;
        cyc(); in_valid = 1'b0; settle();
        check("t1_nib0", out_nibble, 4'h5);
        check("t1_first0", out_first, 1);
        check("t1_valid0", out_valid, 1);
        check("t1_busy", busy, 1);
        cyc();
        check("t1_nib1", out_nibble, 4'hA);
        check("t1_first1", out_first, 0);
        cyc();
        check("t1_idle", out_valid, 0);
        check("t1_cnt", byte_cnt, 1);

        // 2: upper first; cfg_swap toggled mid-byte must be ignored
        in_valid = 1'b1; in_data = 8'hA5; cfg_swap = 1'b1;
        cyc(); in_valid = 1'b0; cfg_swap = 1'b0; settle();
        check("t2_nib0", out_nibble, 4'hA);
        cyc(); cfg_swap = 1'b1; settle();
        check("t2_nib1", out_nibble, 4'h5);
        cyc();
        check("t2_cnt", byte_cnt, 2);

        clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0; settle();
        check("clr_cnt", byte_cnt, 0);

        // 3: back-to-back stream, no bubbles
        cfg_swap = 1'b0; in_valid = 1'b1; in_data = stream[0];
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i % 2 == 1) begin
                in_valid = (i < 5); in_data = (i < 5) ? stream[(i + 1) / 2] : 8'h00;
            end
            settle();
            check($sformatf("t3_valid%0d", i), out_valid, 1);
            check($sformatf("t3_nib%0d", i), out_nibble, exp_nib[i]);
            check($sformatf("t3_first%0d", i), out_first, (i % 2 == 0));
            check($sformatf("t3_ready%0d", i), in_ready, (i % 2 == 1));
        end
        cyc();
        check("t3_idle", out_valid, 0);
        check("t3_cnt", byte_cnt, 3);

        // 4: backpressure in NIB0
        in_valid = 1'b1; in_data = 8'h9C; out_ready = 1'b0;
        cyc(); in_valid = 1'b0; settle();
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_nib", out_nibble, 4'hC);
            check("t4_hold_first", out_first, 1);
            check("t4_hold_ready", in_ready, 0);
            cyc();
        end
        out_ready = 1'b1; settle();
        check("t4_still_nib0", out_nibble, 4'hC);
        cyc();
        check("t4_nib1", out_nibble, 4'h9);
        cyc();
        check("t4_cnt", byte_cnt, 4);

        // 5: last flag on second nibble only, then counter wrap and clear
        in_valid = 1'b1; in_data = 8'hC3; in_last = 1'b1; cfg_swap = 1'b0;
        cyc(); in_valid = 1'b0; in_last = 1'b0; settle();
        check("t5_nib0", out_nibble, 4'h3);
        check("t5_last0", out_last, 0);
        cyc();
        check("t5_nib1", out_nibble, 4'hC);
        check("t5_last1", out_last, 1);
        cyc();
        check("t5_cnt", byte_cnt, 5);
        for (int i = 0; i < 10; i++) send(8'h11, 1'b0, 1'b0, 1'b0);
        check("t5_cnt15", byte_cnt, 15);
        send(8'h22, 1'b0, 1'b0, 1'b0);
        check("t5_wrap", byte_cnt, 0);
        for (int i = 0; i < 15; i++) send(8'h33, 1'b0, 1'b0, 1'b0);
        check("t5_cnt15b", byte_cnt, 15);
        send(8'h44, 1'b0, 1'b0, 1'b1);
        check("t5_clr_wins", byte_cnt, 0);
        send(8'h44, 1'b0, 1'b0, 1'b0);
        check("t5_after_clr", byte_cnt, 1);

        // 6: reset while in NIB1 discards the byte
        in_valid = 1'b1; in_data = 8'h5A; cfg_swap = 1'b0;
        cyc(); in_valid = 1'b0;
        cyc(); settle();
        check("t6_in_nib1", out_nibble, 4'h5);
        rst_n = 1'b0;
        cyc();
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_nib", out_nibble, 0);
        check("t6_rst_first", out_first, 0);
        check("t6_rst_last", out_last, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cnt", byte_cnt, 0);
        check("t6_rst_ready", in_ready, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t6_no_stale", out_valid, 0);
        end
        check("t6_ready_after", in_ready, 1);

`ifdef NIBBLE_PARITY_EN
        check("par_idle", out_parity, 0);
        in_valid = 1'b1; in_data = 8'h37; cfg_swap = 1'b0;
        cyc(); in_valid = 1'b0; settle();
        check("par_nib7", out_parity, 1);
        cyc();
        check("par_nib3", out_parity, 0);
        cyc();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
